data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory responder for the 24-bit RISC processor.
- Accepts load/store requests from the core's data port (address, write data, write enable) and returns read data after a fixed number of wait states.
- Sits between the processor's `da`/`md` outputs and on-chip word storage, so the core can be exercised against realistic memory latency.

Parameters:
- DATA_W, 24, word width in bits.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of words implemented; must be <= 2**ADDR_W.
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address >= DEPTH.
- stat_rd_cnt  out  16  completed in-range loads (see Optional Feature).
- stat_wr_cnt  out  16  completed in-range stores (see Optional Feature).

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, stat counters=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE), decoded from registered state.
  - IDLE: on req_valid && req_ready, capture we/addr/wdata. Go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES==0.
  - WAIT: decrement the counter each cycle; at 0 go to RESP.
  - RESP entry edge:
    - Store: commit the write to memory.
    - Load: register the read data into rsp_rdata.
    - Set rsp_valid=1.
  - RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1. On that edge clear rsp_valid and return to IDLE.
- Latency: a request accepted at edge N has rsp_valid=1 after edge N+1+WAIT_CYCLES.
- Throughput: at most one outstanding request. There is one idle cycle (req_ready=1) between a response handshake and the next acceptance.
- Out-of-range address (addr >= DEPTH): no write, rsp_rdata=0, rsp_err=1, same latency.
- Store response: rsp_rdata=0, rsp_err=0 when in range.
- req_valid in WAIT or RESP is ignored (not accepted); the requester must hold it until req_ready.
- Read-after-write to the same address returns the new data, because the commit precedes any later read.
- Reset mid-operation: the transaction is abandoned. A store not yet at RESP entry is never written. A store already committed stays in memory.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - stat_rd_cnt and stat_wr_cnt increment on each response handshake (rsp_valid && rsp_ready) with rsp_err=0.
  - The counters saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist. The port list is identical in both builds.

Decomposition:
- Package dmem_pkg:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Default DATA_W/ADDR_W constants.
  - Stat counter width 16.
  - Saturation max constant.
- Sub-module dmem_array: single-port synchronous word storage (DEPTH x DATA_W) with write enable and registered read.
- The FSM, wait counter and stats stay in the top module.

Test Plan:
- Reset release, then store addr 8'h05 data 24'hABCDEF with WAIT_CYCLES=2 -> rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
- Load addr 8'h05 after the above -> rsp_rdata=24'hABCDEF at the same latency; with rsp_ready held low 4 cycles, outputs stay stable and req_ready stays 0.
- DEPTH=200, load addr 8'hC8 -> rsp_err=1, rsp_rdata=0. Store 24'h111111 to 8'hC8, then load 8'h00 -> unchanged contents.
- WAIT_CYCLES=0 with back-to-back requests (store 8'h10=24'h000042, then load 8'h10) -> each response 1 cycle after acceptance; load returns 24'h000042; one bubble between transactions.
- Assert rst during WAIT of a store to 8'h20 (previously 24'h00AAAA) -> outputs return to reset values immediately; a later load of 8'h20 returns 24'h00AAAA.
- DMEM_STATS_EN defined: 3 loads, 2 stores, 1 out-of-range load -> stat_rd_cnt=3, stat_wr_cnt=2. Undefined: both read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - FSM state encoding (IDLE, WAIT, RESP)
//   - default word and address widths
//   - statistics counter width and its saturation value
//   - sat_inc(): saturating increment for the statistics counters
package dmem_pkg;

  localparam int DMEM_DATA_W = 24;
  localparam int DMEM_ADDR_W = 8;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counters stick at STAT_MAX instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Single-port synchronous word storage, DEPTH x DATA_W.
// One access per cycle when en=1: a write when we=1, otherwise a read whose
// result lands in the rdata register on the same clock edge. rdata holds its
// value while en=0. Contents are never cleared by reset.
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable
//   we     in   1 = write, 0 = read
//   addr   in   word address (caller guarantees addr < DEPTH when en=1)
//   wdata  in   write data
//   rdata  out  registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-memory responder for the 24-bit RISC core. Accepts one load/store at
// a time, waits WAIT_CYCLES cycles, then performs the memory access and
// presents the response until the core takes it.
// Optional feature: define DMEM_STATS_EN to enable the saturating
// completed-load / completed-store counters; otherwise they read 0.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid/req_ready   request handshake; req_ready = idle
//   req_we                1 = store, 0 = load
//   req_addr, req_wdata   word address, store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data; 0 for stores and errors
//   rsp_err               address was >= DEPTH
//   stat_rd_cnt           completed in-range loads
//   stat_wr_cnt           completed in-range stores
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [STAT_W-1:0] stat_rd_cnt,
  output logic [STAT_W-1:0] stat_wr_cnt
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              accept;
  logic              mem_en, mem_we;
  logic              addr_err;
  logic              cap_we, cap_err;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              rsp_valid_q;
  logic              hs;
  logic [DATA_W-1:0] mem_rdata;

  assign addr_err  = (32'(req_addr) >= 32'(DEPTH));
  assign req_ready = (state == IDLE);
  assign hs        = rsp_valid_q && rsp_ready;

  // The first RESP cycle (rsp_valid still low) is the access cycle: the
  // array commits the store or registers the load on the edge that raises
  // rsp_valid. Out-of-range requests never touch the array.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_n   = CNT_INIT;
          state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (!rsp_valid_q) begin
          mem_en = !cap_err;
          mem_we = cap_we;
        end else if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, wait counter, captured request and response-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      cap_we      <= 1'b0;
      cap_err     <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        cap_we    <= req_we;
        cap_err   <= addr_err;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (state == RESP && !rsp_valid_q) begin
        rsp_valid_q <= 1'b1;
      end else if (hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (cap_addr),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  // The array's read register is the response data register; it is only
  // exposed for a valid, in-range load so stores, errors and reset read 0.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q && cap_err;
  assign rsp_rdata = (rsp_valid_q && !cap_we && !cap_err) ? mem_rdata : '0;

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] rd_cnt, wr_cnt;

  // Count only completed handshakes of in-range requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (hs && !cap_err) begin
      if (cap_we) begin
        wr_cnt <= sat_inc(wr_cnt);
      end else begin
        rd_cnt <= sat_inc(rd_cnt);
      end
    end
  end

  assign stat_rd_cnt = rd_cnt;
  assign stat_wr_cnt = wr_cnt;
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule
